vm_change: RTL and testbench
============================

# vm_change

Parametrised vending-machine controller, successor to the single-product no-change unit. It accumulates deposited coin value and serves a selectable product from a price table. It dispenses when credit covers the price and returns the remainder through a change-valid/acknowledge handshake. Cancel refunds the full credit. Single clock domain; it sits between the coin-acceptor front end and the dispenser/payout mechanics.

## Interface
Parameters:
- `W`, 8: width of coin values, prices, credit and change.
- `N_PROD`, 4: number of products (≥1); `SW = max(1, $clog2(N_PROD))`.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `c`  in  1  coin-deposited strobe, one cycle per coin.
- `a`  in  W  coin value, valid with `c`.
- `price`  in  N_PROD*W  price table; product k at bits `[k*W +: W]`; treated as static while not in IDLE.
- `sel`  in  SW  product select, sampled with `buy`.
- `buy`  in  1  purchase request strobe.
- `cancel`  in  1  refund request strobe.
- `chg_ack`  in  1  payout mechanism accepted the change value.
- `credit`  out  W  current accumulated credit.
- `d`  out  1  dispense pulse, one cycle.
- `d_id`  out  SW  product being dispensed, valid while `d`=1.
- `chg_valid`  out  1  change/refund amount pending.
- `chg`  out  W  change amount, valid while `chg_valid`=1.
- `rej`  out  1  coin rejected pulse; payout returns that coin physically.
- `nak`  out  1  purchase refused pulse: insufficient credit or invalid `sel`.

## Operation
- States: IDLE, DISP, CHANGE. Reset: state IDLE. `credit`, `d`, `d_id`, `chg_valid`, `chg`, `rej` and `nak` are all 0.
- IDLE event priority, evaluated each cycle: `cancel` > `buy` > `c`. When a higher-priority event acts, a simultaneous coin is rejected (`rej`=1) and a simultaneous `buy` is ignored.
- IDLE, `cancel`:
  - `credit`>0: go to CHANGE with `chg`=`credit`.
  - `credit`=0: no-op.
- IDLE, `buy`:
  - `sel`≥N_PROD: `nak`.
  - `credit` < `price[sel]`: `nak`. State and credit are unchanged.
  - Otherwise: `credit` ← `credit` − `price[sel]`; `d_id` ← `sel`; go to DISP.
- IDLE, `c`:
  - If `credit` + `a` fits in W bits (compute in W+1 bits): `credit` ← `credit` + `a`.
  - Otherwise: `rej`=1 and credit is unchanged.
- DISP: `d`=1 for exactly one cycle.
  - Next state CHANGE if `credit`>0, else IDLE.
- CHANGE: `chg_valid`=1 and `chg`=`credit`, both held stable until `chg_ack`=1 is sampled.
  - On ack: `credit` ← 0; `chg_valid` drops; go to IDLE.
- DISP or CHANGE, `c`=1: coin rejected (`rej`). `buy` and `cancel` are ignored.
- Zero-price product: dispenses with credit 0; DISP → IDLE with no change.
- `rst` asserted in any state: next edge forces reset values and discards credit. Pending change is not paid.

## Timing
- All outputs are registered. `rej` and `nak` are single-cycle pulses in the cycle after the offending strobe.
- Coin at edge T: `credit` updated, visible in cycle T+1. Back-to-back coins every cycle are accepted.
- `buy` at edge T, credit sufficient: `d`=1 during T+1 with `credit` already reduced.
  - If there is a remainder: `chg_valid`=1 from T+2.
- `cancel` at edge T, credit>0: `chg_valid`=1 from T+1.
- `chg_ack` sampled high at edge U while `chg_valid`=1: `chg_valid`=0 and `credit`=0 in U+1. The machine accepts new coins at edge U+1.
  - `chg_ack` while `chg_valid`=0 is ignored.
- Purchase latency: buy to `d` is 1 cycle; buy to `chg_valid` is 2 cycles; minimum transaction without change is 2 cycles.

## Test plan
- Exact payment (W=8, price[2]=150): coins 100, 50, then `buy` sel=2. Expect `credit`=150; `d`=1 with `d_id`=2 for one cycle; no `chg_valid`; back in IDLE with credit 0.
- Change with delayed ack: price[1]=75, coins 50, 50, `buy` sel=1. Expect `d` at T+1 and `chg_valid`/`chg`=25 from T+2. Hold `chg_ack` low 5 cycles: `chg` must stay stable. Ack: credit 0 next cycle.
- Insufficient credit and bad select:
  - Credit 20, `buy` sel=0 with price 30: `nak` pulse, credit stays 20.
  - N_PROD=3, `sel`=3: `nak`.
- Overflow and busy rejection:
  - Credit 250, coin 10: `rej`, credit stays 250.
  - Coin during CHANGE: `rej`, `chg` unchanged.
- Simultaneous events: credit 40.
  - `cancel`+`buy`+`c`(a=5) in one cycle: `rej` pulse; `chg_valid` with `chg`=40; no `d`.
  - `cancel` with credit 0: no response.
- Reset mid-CHANGE: `chg_valid`=1 with `chg`=60, assert `rst` one cycle. Expect all outputs 0 next cycle and IDLE. A new coin of 10 then gives `credit`=10.

Source files
------------

// File: rtl/vm_change.sv
// rtl/vm_change.sv - multi-product vending controller with credit, dispense and change handshake
//
// Purpose: accumulates coin value into a credit register and serves a product
// chosen from a price table. When a purchase is accepted, the price is deducted
// and a one-cycle dispense pulse is issued. Any remaining credit is then paid
// out through a valid/ack change handshake. Cancel refunds the whole credit
// through the same handshake.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   c, a       coin strobe and coin value
//   price      packed price table, product k at [k*W +: W]
//   sel, buy   product select and purchase strobe
//   cancel     refund request strobe
//   chg_ack    payout mechanism accepted chg
//   credit     accumulated credit
//   d, d_id    dispense pulse and product id
//   chg_valid  change amount pending; chg holds the amount
//   rej        coin rejected pulse
//   nak        purchase refused pulse

module vm_change #(
    parameter  int W      = 8,
    parameter  int N_PROD = 4,
    localparam int SW     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                c,
    input  logic [W-1:0]        a,
    input  logic [N_PROD*W-1:0] price,
    input  logic [SW-1:0]       sel,
    input  logic                buy,
    input  logic                cancel,
    input  logic                chg_ack,
    output logic [W-1:0]        credit,
    output logic                d,
    output logic [SW-1:0]       d_id,
    output logic                chg_valid,
    output logic [W-1:0]        chg,
    output logic                rej,
    output logic                nak
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISP,
        S_CHANGE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_credit;
    logic          r_d;
    logic [SW-1:0] r_d_id;
    logic          r_chg_valid;
    logic [W-1:0]  r_chg;
    logic          r_rej;
    logic          r_nak;

    logic [W-1:0]  w_price;
    logic          w_sel_ok;
    logic [W:0]    w_sum;
    logic          w_afford;
    logic          w_has_credit;

    // Price lookup. sel may exceed N_PROD-1 when N_PROD is not a power of
    // two; w_sel_ok flags a select that matched a real table entry.
    always_comb begin
        w_price  = '0;
        w_sel_ok = 1'b0;
        for (int k = 0; k < N_PROD; k++) begin
            if (sel == SW'(k)) begin
                w_price  = price[k*W +: W];
                w_sel_ok = 1'b1;
            end
        end
    end

    // One extra bit catches coin overflow instead of silently wrapping.
    assign w_sum        = {1'b0, r_credit} + {1'b0, a};
    assign w_afford     = (r_credit >= w_price);
    assign w_has_credit = (r_credit != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_credit    <= '0;
            r_d         <= 1'b0;
            r_d_id      <= '0;
            r_chg_valid <= 1'b0;
            r_chg       <= '0;
            r_rej       <= 1'b0;
            r_nak       <= 1'b0;
        end else begin
            r_d   <= 1'b0;
            r_rej <= 1'b0;
            r_nak <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cancel) begin
                        // Cancel outranks everything; a coin arriving in the
                        // same cycle is bounced back.
                        r_rej <= c;
                        if (w_has_credit) begin
                            r_chg_valid <= 1'b1;
                            r_chg       <= r_credit;
                            r_state     <= S_CHANGE;
                        end
                    end else if (buy) begin
                        r_rej <= c;
                        if (!w_sel_ok || !w_afford) begin
                            r_nak <= 1'b1;
                        end else begin
                            r_credit <= r_credit - w_price;
                            r_d_id   <= sel;
                            r_d      <= 1'b1;
                            r_state  <= S_DISP;
                        end
                    end else if (c) begin
                        if (w_sum[W]) begin
                            r_rej <= 1'b1;
                        end else begin
                            r_credit <= w_sum[W-1:0];
                        end
                    end
                end

                S_DISP: begin
                    // r_credit already holds the remainder after the price
                    // was deducted on entry.
                    r_rej <= c;
                    if (w_has_credit) begin
                        r_chg_valid <= 1'b1;
                        r_chg       <= r_credit;
                        r_state     <= S_CHANGE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_CHANGE: begin
                    r_rej <= c;
                    if (chg_ack) begin
                        r_credit    <= '0;
                        r_chg_valid <= 1'b0;
                        r_chg       <= '0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign credit    = r_credit;
    assign d         = r_d;
    assign d_id      = r_d_id;
    assign chg_valid = r_chg_valid;
    assign chg       = r_chg;
    assign rej       = r_rej;
    assign nak       = r_nak;

endmodule

// File: tb/tb_vm_change.sv
// tb/tb_vm_change.sv - self-checking bench for vm_change against a transaction-level model

module tb_vm_change;

    localparam int W      = 8;
    localparam int N_PROD = 3;
    localparam int SW     = 2;

    localparam int P_IDLE    = 0;
    localparam int P_DISPENSE = 1;
    localparam int P_PAYING  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                c;
    logic [W-1:0]        a;
    logic [N_PROD*W-1:0] price;
    logic [SW-1:0]       sel;
    logic                buy;
    logic                cancel;
    logic                chg_ack;
    logic [W-1:0]        credit;
    logic                d;
    logic [SW-1:0]       d_id;
    logic                chg_valid;
    logic [W-1:0]        chg;
    logic                rej;
    logic                nak;

    int n_tests = 0;
    int n_fail  = 0;

    int m_credit;
    int m_phase;
    int e_d, e_did, e_rej, e_nak;

    always #5 clk = ~clk;

    vm_change #(.W(W), .N_PROD(N_PROD)) dut (
        .clk(clk), .rst(rst), .c(c), .a(a), .price(price), .sel(sel),
        .buy(buy), .cancel(cancel), .chg_ack(chg_ack),
        .credit(credit), .d(d), .d_id(d_id), .chg_valid(chg_valid),
        .chg(chg), .rej(rej), .nak(nak)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int price_of(input int k);
        return int'(price[k*W +: W]);
    endfunction

    // Reference model: applies the purchase rules to plain integers.
    task automatic model_step();
        e_d = 0; e_rej = 0; e_nak = 0;
        if (rst) begin
            m_credit = 0;
            m_phase  = P_IDLE;
        end else if (m_phase == P_IDLE) begin
            if (cancel) begin
                e_rej = c;
                if (m_credit > 0) m_phase = P_PAYING;
            end else if (buy) begin
                e_rej = c;
                if (int'(sel) >= N_PROD || m_credit < price_of(int'(sel))) begin
                    e_nak = 1;
                end else begin
                    m_credit = m_credit - price_of(int'(sel));
                    e_d   = 1;
                    e_did = int'(sel);
                    m_phase = P_DISPENSE;
                end
            end else if (c) begin
                if (m_credit + int'(a) > 255) e_rej = 1;
                else m_credit = m_credit + int'(a);
            end
        end else if (m_phase == P_DISPENSE) begin
            e_rej = c;
            m_phase = (m_credit > 0) ? P_PAYING : P_IDLE;
        end else begin
            e_rej = c;
            if (chg_ack) begin
                m_credit = 0;
                m_phase  = P_IDLE;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
        check("credit", credit, m_credit);
        check("d", d, e_d);
        if (e_d != 0) check("d_id", d_id, e_did);
        check("chg_valid", chg_valid, (m_phase == P_PAYING) ? 1 : 0);
        if (m_phase == P_PAYING) check("chg", chg, m_credit);
        check("rej", rej, e_rej);
        check("nak", nak, e_nak);
    endtask

    task automatic idle_in();
        rst = 0; c = 0; a = '0; sel = '0; buy = 0; cancel = 0; chg_ack = 0;
    endtask

    task automatic coin(input int v);
        idle_in(); c = 1; a = W'(v); cycle(); idle_in();
    endtask

    task automatic do_buy(input int s);
        idle_in(); buy = 1; sel = SW'(s); cycle(); idle_in();
    endtask

    task automatic do_cancel();
        idle_in(); cancel = 1; cycle(); idle_in();
    endtask

    task automatic do_ack();
        idle_in(); chg_ack = 1; cycle(); idle_in();
    endtask

    task automatic do_reset();
        idle_in(); rst = 1; cycle(); idle_in();
    endtask

    initial begin
        m_credit = 0; m_phase = P_IDLE; e_did = 0;
        idle_in();
        price = {8'd150, 8'd75, 8'd30};
        do_reset();
        check("reset_credit", credit, 0);
        check("reset_chg_valid", chg_valid, 0);

        // Exact payment
        coin(100); coin(50);
        check("exact_credit", credit, 150);
        do_buy(2);
        check("exact_d", d, 1);
        check("exact_d_id", d_id, 2);
        idle_in(); cycle();
        check("exact_no_chg", chg_valid, 0);
        check("exact_credit0", credit, 0);

        // Change with delayed ack
        coin(50); coin(50); do_buy(1);
        check("chg_d", d, 1);
        idle_in(); cycle();
        check("chg_valid_t2", chg_valid, 1);
        for (int i = 0; i < 5; i++) begin
            idle_in(); cycle();
            check("chg_hold", chg, 25);
        end
        do_ack();
        check("chg_ack_credit", credit, 0);
        check("chg_ack_valid", chg_valid, 0);

        // Insufficient credit and bad select
        coin(20); do_buy(0);
        check("nak_low", nak, 1);
        check("nak_credit", credit, 20);
        do_buy(3);
        check("nak_sel", nak, 1);
        do_cancel(); do_ack();

        // Overflow and busy rejection
        coin(250); coin(10);
        check("ovf_rej", rej, 1);
        check("ovf_credit", credit, 250);
        do_cancel();
        idle_in(); c = 1; a = 8'd5; cycle(); idle_in();
        check("busy_rej", rej, 1);
        check("busy_chg", chg, 250);
        do_ack();

        // Simultaneous events
        coin(40);
        idle_in(); cancel = 1; buy = 1; sel = 2'd0; c = 1; a = 8'd5; cycle(); idle_in();
        check("sim_rej", rej, 1);
        check("sim_chg", chg, 40);
        check("sim_no_d", d, 0);
        do_ack();
        do_cancel();
        check("cancel0_valid", chg_valid, 0);
        check("cancel0_rej", rej, 0);

        // Reset mid-change
        coin(60); do_cancel();
        check("rst_pre_chg", chg, 60);
        do_reset();
        check("rst_chg_valid", chg_valid, 0);
        check("rst_credit", credit, 0);
        coin(10);
        check("rst_then_coin", credit, 10);

        // Zero-price product
        do_reset();
        price = {8'd150, 8'd75, 8'd0};
        do_buy(0);
        check("zero_d", d, 1);
        idle_in(); cycle();
        check("zero_no_chg", chg_valid, 0);

        // Randomized traffic, price table reloaded from reset between blocks
        for (int blk = 0; blk < 8; blk++) begin
            do_reset();
            price = {W'($urandom_range(0, 200)), W'($urandom_range(0, 120)),
                     ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 60))};
            for (int i = 0; i < 400; i++) begin
                idle_in();
                c       = ($urandom_range(0, 1) == 1);
                a       = ($urandom_range(0, 7) == 0) ? W'($urandom_range(100, 255))
                                                      : W'($urandom_range(0, 40));
                buy     = ($urandom_range(0, 5) == 0);
                sel     = SW'($urandom_range(0, 3));
                cancel  = ($urandom_range(0, 11) == 0);
                chg_ack = ($urandom_range(0, 2) == 0);
                rst     = ($urandom_range(0, 299) == 0);
                // Keep clear of combinations whose coin handling is not pinned down.
                if (m_phase == P_IDLE && cancel && m_credit == 0) begin
                    buy = 0; c = 0;
                end
                if (m_phase == P_IDLE && !cancel && buy &&
                    (int'(sel) >= N_PROD || m_credit < price_of(int'(sel)))) c = 0;
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
